scaler_row_sched: RTL and testbench
===================================

# scaler_row_sched

Vertical row scheduler for the scaler stream core. Per frame it walks the vertical scale factor over the destination rows and waits until the line buffer holds the source rows each kernel window needs. It then fires one `h_start` per destination row into the horizontal LUT stage and presents the vertical kernel phase and source base row for that pass. It also releases source lines back to the line buffer writer once no later destination row can reference them.

## Interface
- `IMG_V_MAX`, 1080, maximum source/destination rows
- `IMG_V_BITWIDTH`, CLOG2(IMG_V_MAX), row index width
- `KERNEL_MAX`, 4, kernel rows needed per output row (≥2)
- `KERNEL_BITWIDTH`, CLOG2(KERNEL_MAX), phase width
- `SF_BITWIDTH`, 24, scale factor width (24Q20)
- `SF_FRAC_BITWIDTH`, 20, scale factor fraction bits
- `core_clk`  in  1  sole clock
- `core_rst_n`  in  1  reset, synchronous, active-low
- `core_arg_img_src_v`  in  IMG_V_BITWIDTH  source rows; static while `busy`
- `core_arg_img_des_v`  in  IMG_V_BITWIDTH  destination rows; static while `busy`
- `core_arg_vsf`  in  SF_BITWIDTH  vertical step src/des, 24Q20; static while `busy`
- `frame_start`  in  1  one-cycle frame start pulse
- `line_in_done`  in  1  pulse: one more source row fully written to line buffer
- `h_start`  out  1  one-cycle start pulse to horizontal LUT stage
- `h_done`  in  1  pulse: horizontal pass for current row complete
- `row_src_base`  out  IMG_V_BITWIDTH  integer source row at top of kernel
- `row_v_phase`  out  KERNEL_BITWIDTH  vertical kernel phase
- `line_free`  out  1  pulse: one source row released, oldest first
- `busy`  out  1  frame in progress
- `frame_done`  out  1  one-cycle pulse: frame complete and all lines released

## Operation
- States: IDLE, WAIT, START, RUN, NEXT, FLUSH.
- IDLE: on `frame_start`, clear `v_acc` (IMG_V_BITWIDTH+SF_FRAC_BITWIDTH bits), `out_row`, `lines_avail` and `freed_cnt`, then go to WAIT. If `core_arg_img_des_v`==0, go to FLUSH instead.
- `v_acc` integer part is `base`. `need` = min(`base`+KERNEL_MAX, `src_v`).
- WAIT: when `lines_avail` ≥ `need`, latch `row_src_base`=`base` and `row_v_phase`=top KERNEL_BITWIDTH bits of the fraction (<¼→0, <½→1, <¾→2, else 3). Then go to START.
- START: `h_start`=1 for exactly this cycle, then go to RUN.
- RUN: wait for `h_done`, then go to NEXT.
- NEXT: `v_acc` += `core_arg_vsf` (zero-extended), `out_row`++. If the new `out_row`==`des_v`, go to FLUSH, else go to WAIT.
- `lines_avail`: +1 per `line_in_done`, saturates at `src_v`. It counts in every state except IDLE.
- Release: while `freed_cnt` < `base` (FLUSH: < `src_v`), emit `line_free` one cycle at a time and increment `freed_cnt`. This runs concurrently with WAIT/START/RUN. Downscale can therefore produce several consecutive pulses.
- FLUSH: once `freed_cnt`==`src_v`, pulse `frame_done`, deassert `busy` and return to IDLE.
- `busy`=1 in every state except IDLE.
- `frame_start` while `busy` is ignored.
- `h_done` outside RUN is ignored.
- `line_in_done` in IDLE is ignored.
- `line_in_done` and a WAIT check in the same cycle: the check uses the registered count, so the new line takes effect one cycle later.
- Reset mid-frame: all state is discarded, the block returns to IDLE and every output takes its reset value.

## Timing
- Reset values: `h_start`=0, `line_free`=0, `busy`=0, `frame_done`=0, `row_src_base`=0, `row_v_phase`=0.
- All outputs are registered.
- `frame_start` at cycle T with lines available: `busy`=1 from T+1, `h_start` at T+3 earliest.
- `h_done` at T with next rows available: next `h_start` at T+4 (NEXT, WAIT, START).
- `row_src_base` and `row_v_phase` are stable from the `h_start` cycle until the following NEXT.
- `line_free` rate: at most 1 per cycle. Rows ≥ `row_src_base` are never freed before the current `h_done`.

## Structure
- Shared package `scaler_pkg`: CLOG2 function, SF_BITWIDTH / SF_FRAC_BITWIDTH constants, phase quantization function.
- One sub-module, `scaler_line_credit`: the `lines_avail` saturating counter, `freed_cnt` and the `line_free` pulse generator, fed by `base`/flush target.
- The FSM and accumulator stay in the top module.

## Test plan
- 1:1 case, src_v=des_v=8, vsf=0x100000, lines streamed: 8 `h_start`, bases 0..7, phase 0. `h_start` for row r only after `lines_avail` ≥ min(r+4,8). 8 `line_free` pulses, then `frame_done`.
- Downscale 12→4, vsf=0x300000: bases 0,3,6,9, phase 0. `line_free` bursts of 3 after each advance. Total 12 frees before `frame_done`.
- Upscale 4→8, vsf=0x080000: bases 0,0,1,1,2,2,3,3, phases 0,2,0,2,…. First `h_start` only after 4 lines. `line_free` total 4.
- Lines withheld: after `h_done`, `line_in_done` delayed 20 cycles. `h_start` must not assert until `lines_avail` reaches `need`. `busy` stays high throughout.
- `frame_start` during RUN and a stray `h_done` in WAIT: no effect on state or outputs. `des_v`=0: `frame_done` with no `h_start`.
- `core_rst_n` low while in RUN: next cycle all outputs are 0 and the state is IDLE. A new `frame_start` then runs a clean frame.

Source files
------------

// File: rtl/scaler_pkg.sv
// Shared constants, state encoding and helpers for the scaler stream core.
package scaler_pkg;

  localparam int SF_BITWIDTH      = 24;
  localparam int SF_FRAC_BITWIDTH = 20;
  localparam int PHASE_W_MAX      = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_START,
    ST_RUN,
    ST_NEXT,
    ST_FLUSH
  } row_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

  // Keeps only the top phase_w bits of the fraction, i.e. quantises it into 2**phase_w equal bins.
  function automatic logic [PHASE_W_MAX-1:0] quant_phase(
    input logic [SF_FRAC_BITWIDTH-1:0] frac,
    input int                          phase_w
  );
    return PHASE_W_MAX'(frac >> (SF_FRAC_BITWIDTH - phase_w));
  endfunction

endpackage

// File: rtl/scaler_line_credit.sv
// Line buffer credit: counts written source rows and releases consumed rows one per cycle, oldest first.
module scaler_line_credit
  import scaler_pkg::*;
#(
  parameter int ROW_W = 11
) (
  input  logic             core_clk,
  input  logic             core_rst_n,
  input  logic             clr,
  input  logic             cnt_en,
  input  logic             line_in_done,
  input  logic             rel_en,
  input  logic [ROW_W-1:0] src_v,
  input  logic [ROW_W-1:0] rel_target,
  output logic [ROW_W-1:0] lines_avail,
  output logic [ROW_W-1:0] freed_cnt,
  output logic             line_free
);

  logic [ROW_W-1:0] lines_avail_q, lines_avail_d;
  logic [ROW_W-1:0] freed_cnt_q, freed_cnt_d;
  logic             line_free_q, line_free_d;
  logic             release_fire;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    lines_avail_d = lines_avail_q;
    freed_cnt_d   = freed_cnt_q;
    release_fire  = rel_en && (freed_cnt_q < rel_target);
    line_free_d   = release_fire;
    if (clr) begin
      lines_avail_d = '0;
      freed_cnt_d   = '0;
      line_free_d   = 1'b0;
    end else begin
      if (cnt_en && line_in_done && (lines_avail_q < src_v)) begin
        lines_avail_d = lines_avail_q + ROW_W'(1);
      end
      if (release_fire) begin
        freed_cnt_d = freed_cnt_q + ROW_W'(1);
      end
    end
  end

  // NOTE: non-blocking updates make every flop sample pre-edge values; reset is synchronous and clears all state.
  always_ff @(posedge core_clk) begin
    if (!core_rst_n) begin
      lines_avail_q <= '0;
      freed_cnt_q   <= '0;
      line_free_q   <= 1'b0;
    end else begin
      lines_avail_q <= lines_avail_d;
      freed_cnt_q   <= freed_cnt_d;
      line_free_q   <= line_free_d;
    end
  end

  assign lines_avail = lines_avail_q;
  assign freed_cnt   = freed_cnt_q;
  assign line_free   = line_free_q;

endmodule

// File: rtl/scaler_row_sched.sv
// Vertical row scheduler: steps the vertical scale accumulator per destination row, gates each
// horizontal pass on line buffer occupancy and hands finished source rows back to the writer.
module scaler_row_sched
  import scaler_pkg::*;
#(
  parameter int IMG_V_MAX        = 1080,
  parameter int IMG_V_BITWIDTH   = scaler_pkg::clog2(IMG_V_MAX),
  parameter int KERNEL_MAX       = 4,
  parameter int KERNEL_BITWIDTH  = scaler_pkg::clog2(KERNEL_MAX),
  parameter int SF_BITWIDTH      = scaler_pkg::SF_BITWIDTH,
  parameter int SF_FRAC_BITWIDTH = scaler_pkg::SF_FRAC_BITWIDTH
) (
  input  logic                       core_clk,
  input  logic                       core_rst_n,
  input  logic [IMG_V_BITWIDTH-1:0]  core_arg_img_src_v,
  input  logic [IMG_V_BITWIDTH-1:0]  core_arg_img_des_v,
  input  logic [SF_BITWIDTH-1:0]     core_arg_vsf,
  input  logic                       frame_start,
  input  logic                       line_in_done,
  output logic                       h_start,
  input  logic                       h_done,
  output logic [IMG_V_BITWIDTH-1:0]  row_src_base,
  output logic [KERNEL_BITWIDTH-1:0] row_v_phase,
  output logic                       line_free,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int ROW_W = IMG_V_BITWIDTH;
  localparam int ACC_W = IMG_V_BITWIDTH + SF_FRAC_BITWIDTH;
  localparam logic [ROW_W:0] KERNEL_ROWS = (ROW_W + 1)'(KERNEL_MAX);

  row_state_e                 state_q, state_d;
  logic [ACC_W-1:0]           v_acc_q, v_acc_d;
  logic [ROW_W-1:0]           out_row_q, out_row_d;
  logic [ROW_W-1:0]           row_src_base_q, row_src_base_d;
  logic [KERNEL_BITWIDTH-1:0] row_v_phase_q, row_v_phase_d;
  logic                       h_start_q, h_start_d;
  logic                       busy_q, busy_d;
  logic                       frame_done_q, frame_done_d;

  logic [ROW_W-1:0] base;
  logic [ROW_W:0]   need;
  logic [ROW_W-1:0] rel_target;
  logic [ROW_W-1:0] lines_avail;
  logic [ROW_W-1:0] freed_cnt;
  logic             lines_ready;
  logic             credit_clr;
  logic             credit_en;

  assign base = v_acc_q[ACC_W-1:SF_FRAC_BITWIDTH];

  // The kernel window is clipped at the bottom edge of the source image.
  always_comb begin
    need = {1'b0, base} + KERNEL_ROWS;
    if (need > {1'b0, core_arg_img_src_v}) begin
      need = {1'b0, core_arg_img_src_v};
    end
  end

  assign lines_ready = ({1'b0, lines_avail} >= need);

  // Rows above the current base can no longer be referenced; at flush everything goes.
  always_comb begin
    rel_target = base;
    if ((state_q == ST_FLUSH) || (base > core_arg_img_src_v)) begin
      rel_target = core_arg_img_src_v;
    end
  end

  assign credit_en = (state_q != ST_IDLE);

  scaler_line_credit #(
    .ROW_W (ROW_W)
  ) u_line_credit (
    .core_clk     (core_clk),
    .core_rst_n   (core_rst_n),
    .clr          (credit_clr),
    .cnt_en       (credit_en),
    .line_in_done (line_in_done),
    .rel_en       (credit_en),
    .src_v        (core_arg_img_src_v),
    .rel_target   (rel_target),
    .lines_avail  (lines_avail),
    .freed_cnt    (freed_cnt),
    .line_free    (line_free)
  );

  always_comb begin
    state_d        = state_q;
    v_acc_d        = v_acc_q;
    out_row_d      = out_row_q;
    row_src_base_d = row_src_base_q;
    row_v_phase_d  = row_v_phase_q;
    frame_done_d   = 1'b0;
    credit_clr     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          v_acc_d    = '0;
          out_row_d  = '0;
          credit_clr = 1'b1;
          state_d    = (core_arg_img_des_v == '0) ? ST_FLUSH : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lines_ready) begin
          row_src_base_d = base;
          row_v_phase_d  = KERNEL_BITWIDTH'(quant_phase(v_acc_q[SF_FRAC_BITWIDTH-1:0], KERNEL_BITWIDTH));
          state_d        = ST_START;
        end
      end
      ST_START: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (h_done) begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        v_acc_d   = v_acc_q + ACC_W'(core_arg_vsf);
        out_row_d = out_row_q + ROW_W'(1);
        state_d   = (out_row_d == core_arg_img_des_v) ? ST_FLUSH : ST_WAIT;
      end
      ST_FLUSH: begin
        if (freed_cnt == core_arg_img_src_v) begin
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pulse outputs are registered off the current state, so h_start lands one cycle after START.
  assign h_start_d = (state_q == ST_START);
  assign busy_d    = (state_d != ST_IDLE);

  always_ff @(posedge core_clk) begin
    if (!core_rst_n) begin
      state_q        <= ST_IDLE;
      v_acc_q        <= '0;
      out_row_q      <= '0;
      row_src_base_q <= '0;
      row_v_phase_q  <= '0;
      h_start_q      <= 1'b0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      v_acc_q        <= v_acc_d;
      out_row_q      <= out_row_d;
      row_src_base_q <= row_src_base_d;
      row_v_phase_q  <= row_v_phase_d;
      h_start_q      <= h_start_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign h_start      = h_start_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign row_src_base = row_src_base_q;
  assign row_v_phase  = row_v_phase_q;

endmodule

// File: tb/tb_scaler_row_sched.sv
// Randomised bench for scaler_row_sched against a frame-level model of row bases, phases and timing.
module tb_scaler_row_sched;

  localparam int ROW_W = 11;
  localparam int KW    = 2;
  localparam int BUDGET = 4000;

  logic             core_clk = 1'b0;
  logic             core_rst_n;
  logic [ROW_W-1:0] core_arg_img_src_v;
  logic [ROW_W-1:0] core_arg_img_des_v;
  logic [23:0]      core_arg_vsf;
  logic             frame_start;
  logic             line_in_done;
  logic             h_start;
  logic             h_done;
  logic [ROW_W-1:0] row_src_base;
  logic [KW-1:0]    row_v_phase;
  logic             line_free;
  logic             busy;
  logic             frame_done;

  int n_checks = 0;
  int n_errors = 0;

  scaler_row_sched dut (
    .core_clk           (core_clk),
    .core_rst_n         (core_rst_n),
    .core_arg_img_src_v (core_arg_img_src_v),
    .core_arg_img_des_v (core_arg_img_des_v),
    .core_arg_vsf       (core_arg_vsf),
    .frame_start        (frame_start),
    .line_in_done       (line_in_done),
    .h_start            (h_start),
    .h_done             (h_done),
    .row_src_base       (row_src_base),
    .row_v_phase        (row_v_phase),
    .line_free          (line_free),
    .busy               (busy),
    .frame_done         (frame_done)
  );

  always #5 core_clk = ~core_clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge core_clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_h_start"}, int'(h_start), 0);
    check({tag, "_line_free"}, int'(line_free), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
    check({tag, "_base"}, int'(row_src_base), 0);
    check({tag, "_phase"}, int'(row_v_phase), 0);
  endtask

  // One frame. Expected rows come from r*vsf directly; h_start timing is the earliest cycle two
  // after a WAIT cycle whose registered line count (lines sent up to the previous cycle) covers need.
  task automatic run_frame(input int src, input int des, input int unsigned vsf,
                           input bit withhold, input bit stray, input bit fast, input int abort_row);
    int     exp_base[$];
    int     exp_phase[$];
    int     exp_need[$];
    int     sent_at[BUDGET];
    longint acc;
    int     nb, sent, hs, frees, limit, wait_start, hold, delay, exp_c, c;
    bit     outstanding, done;

    for (int r = 0; r < des; r++) begin
      acc = longint'(r) * longint'(vsf);
      nb  = int'(acc >> 20);
      exp_base.push_back(nb);
      exp_phase.push_back(int'((acc >> 18) & 64'd3));
      exp_need.push_back((nb + 4 < src) ? nb + 4 : src);
    end

    core_arg_img_src_v = ROW_W'(src);
    core_arg_img_des_v = ROW_W'(des);
    core_arg_vsf       = 24'(vsf);
    line_in_done       = 1'b0;
    h_done             = 1'b0;
    frame_start        = 1'b1;
    step();
    frame_start = 1'b0;
    check("busy_rise", int'(busy), 1);

    sent = 0; hs = 0; frees = 0; hold = 0; delay = 0;
    outstanding = 1'b0; done = 1'b0;
    sent_at[0] = 0;
    wait_start = 1;
    if (des > 0) limit = (exp_base[0] < src) ? exp_base[0] : src;
    else         limit = src;

    for (c = 1; c < BUDGET && !done; c++) begin
      if (line_free) begin
        check("free_order", int'(frees < limit), 1);
        frees++;
      end
      if (!frame_done) check("busy_hold", int'(busy), 1);
      if (h_start) begin
        if (hs >= des) begin
          check("hs_count", hs + 1, des);
        end else begin
          exp_c = -1;
          for (int x = wait_start; x <= c - 2; x++) begin
            if (sent_at[x-1] >= exp_need[hs]) begin
              exp_c = x + 2;
              break;
            end
          end
          check("hs_cycle", c, exp_c);
          check("row_base", int'(row_src_base), exp_base[hs]);
          check("row_phase", int'(row_v_phase), exp_phase[hs]);
          outstanding = 1'b1;
          delay = $urandom_range(1, 6);
        end
        hs++;
        if (hs - 1 == abort_row) begin
          line_in_done = 1'b0;
          h_done       = 1'b0;
          core_rst_n   = 1'b0;
          step();
          check_all_zero("rst_mid");
          core_rst_n = 1'b1;
          repeat (2) step();
          check_all_zero("rst_idle");
          return;
        end
      end
      if (frame_done) begin
        check("done_rows", hs, des);
        check("done_frees", frees, src);
        check("done_busy", int'(busy), 0);
        done = 1'b1;
      end

      line_in_done = 1'b0;
      h_done       = 1'b0;
      frame_start  = 1'b0;
      if (!done) begin
        if (hold > 0) begin
          hold--;
        end else if (sent < src && (fast || $urandom_range(0, 1) == 1)) begin
          line_in_done = 1'b1;
          sent++;
        end
        if (outstanding) begin
          if (delay == 0) begin
            check("base_hold", int'(row_src_base), exp_base[hs-1]);
            check("phase_hold", int'(row_v_phase), exp_phase[hs-1]);
            h_done      = 1'b1;
            outstanding = 1'b0;
            wait_start  = c + 2;
            if (hs < des) limit = (exp_base[hs] < src) ? exp_base[hs] : src;
            else          limit = src;
            if (withhold) hold = 20;
          end else begin
            delay--;
          end
        end else if (stray && !h_start && $urandom_range(0, 7) == 0) begin
          h_done = 1'b1;
        end
        if (stray && busy && $urandom_range(0, 7) == 0) frame_start = 1'b1;
      end
      sent_at[c] = sent;
      step();
    end
    if (!done) check("frame_timeout", 0, 1);

    line_in_done = 1'b0;
    h_done       = 1'b0;
    frame_start  = 1'b0;
    repeat (3) begin
      check("idle_quiet", int'({h_start, line_free, busy, frame_done}), 0);
      step();
    end
  endtask

  initial begin
    int src, des, lo;
    core_rst_n         = 1'b0;
    core_arg_img_src_v = '0;
    core_arg_img_des_v = '0;
    core_arg_vsf       = '0;
    frame_start        = 1'b0;
    line_in_done       = 1'b0;
    h_done             = 1'b0;
    repeat (3) step();
    check_all_zero("reset");
    core_rst_n = 1'b1;
    step();

    run_frame(8, 8, 32'h100000, 1'b0, 1'b0, 1'b1, -1);
    run_frame(12, 4, 32'h300000, 1'b0, 1'b0, 1'b0, -1);
    run_frame(4, 8, 32'h080000, 1'b0, 1'b0, 1'b0, -1);
    run_frame(8, 8, 32'h100000, 1'b1, 1'b0, 1'b0, -1);
    run_frame(16, 10, (32'd16 << 20) / 32'd10, 1'b0, 1'b1, 1'b0, -1);
    run_frame(5, 0, 32'h100000, 1'b0, 1'b0, 1'b0, -1);
    run_frame(10, 10, 32'h100000, 1'b0, 1'b0, 1'b1, 2);
    run_frame(6, 9, (32'd6 << 20) / 32'd9, 1'b0, 1'b1, 1'b1, -1);

    for (int i = 0; i < 12; i++) begin
      src = $urandom_range(1, 40);
      lo  = src / 8 + 1;
      des = $urandom_range(lo, 48);
      run_frame(src, des, (32'(src) << 20) / 32'(des),
                $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
